// File: rtl/pipe_stage_reg_if.sv
// Pipeline stage handshake bundle.
// Groups the upstream beat (in_*), the downstream beat (out_*), the flush
// request and the flush-bubble indicator so that a stage register and its
// neighbours share one connection.
//   master : drives flush, in_valid/pc/ir/data/ctrl and out_ready;
//            observes in_ready, out_valid/pc/ir/data/ctrl and out_flushed.
//   slave  : the stage register itself (directions mirrored).
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 24
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_pc;
  logic [31:0]       in_ir;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_pc;
  logic [31:0]       out_ir;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_flushed;

  modport master (
    output flush, in_valid, in_pc, in_ir, in_data, in_ctrl, out_ready,
    input  in_ready, out_valid, out_pc, out_ir, out_data, out_ctrl, out_flushed
  );

  modport slave (
    input  flush, in_valid, in_pc, in_ir, in_data, in_ctrl, out_ready,
    output in_ready, out_valid, out_pc, out_ir, out_data, out_ctrl, out_flushed
  );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake and flush.
// Holds one instruction beat (pc, ir, operand payload, control bundle) between
// two pipeline stages. Flush turns the stage into a bubble: NOP instruction,
// side-effecting control bits cleared, PC taken from the incoming beat.
//
// Ports:
//   clk  - single clock, rising edge
//   rst  - synchronous, active-high reset
//   bus  - pipe_stage_reg_if.slave: flush, in_* (upstream beat, in_ready),
//          out_* (downstream beat, out_ready), out_flushed
//
// Build option:
//   PIPE_STAGE_SKID_EN defined   -> registered in_ready with a one-entry skid
//                                   buffer (states EMPTY / FULL / SKID).
//   PIPE_STAGE_SKID_EN undefined -> combinational in_ready, no skid storage.
module pipe_stage_reg #(
  parameter int unsigned       DATA_W    = 64,
  parameter int unsigned       CTRL_W    = 24,
  parameter logic [CTRL_W-1:0] KILL_MASK = '1,
  parameter logic [31:0]       NOP_IR    = 32'h0000_0013
) (
  input logic             clk,
  input logic             rst,
  pipe_stage_reg_if.slave bus
);

  logic              in_ready_i;
  logic              out_valid_i;
  logic              in_xfer;
  logic              out_xfer;

  // Main (output) register load request and its source.
  logic              load_main;
  logic [31:0]       main_pc_d;
  logic [31:0]       main_ir_d;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_d;

  logic [31:0]       pc_q;
  logic [31:0]       ir_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              flushed_q;

  // A beat offered together with flush is never taken.
  assign in_xfer  = bus.in_valid && in_ready_i && !bus.flush;
  assign out_xfer = out_valid_i && bus.out_ready;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ready_q;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;
  logic [31:0]       skid_pc;
  logic [31:0]       skid_ir;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nxt;
      // in_ready is registered: it only drops once the skid entry is occupied.
      ready_q <= (state_nxt != SKID);
    end
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          state_nxt    = FULL;
          load_main_in = 1'b1;
        end
      end
      FULL: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (in_xfer) begin
          state_nxt = SKID;
          load_skid = 1'b1;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      SKID: begin
        if (out_xfer) begin
          state_nxt      = FULL;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (bus.flush) begin
      state_nxt      = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_pc   <= '0;
      skid_ir   <= NOP_IR;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (load_skid) begin
      skid_pc   <= bus.in_pc;
      skid_ir   <= bus.in_ir;
      skid_data <= bus.in_data;
      skid_ctrl <= bus.in_ctrl;
    end
  end

  assign load_main   = load_main_in || load_main_skid;
  assign main_pc_d   = load_main_skid ? skid_pc   : bus.in_pc;
  assign main_ir_d   = load_main_skid ? skid_ir   : bus.in_ir;
  assign main_data_d = load_main_skid ? skid_data : bus.in_data;
  assign main_ctrl_d = load_main_skid ? skid_ctrl : bus.in_ctrl;
  assign out_valid_i = (state != EMPTY);
  assign in_ready_i  = ready_q;

`else

  logic valid_q;

  assign in_ready_i = !valid_q || bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (in_xfer) begin
      valid_q <= 1'b1;
    end else if (out_xfer) begin
      valid_q <= 1'b0;
    end
  end

  assign load_main   = in_xfer;
  assign main_pc_d   = bus.in_pc;
  assign main_ir_d   = bus.in_ir;
  assign main_data_d = bus.in_data;
  assign main_ctrl_d = bus.in_ctrl;
  assign out_valid_i = valid_q;

`endif

  // Output register. Flush leaves a bubble carrying the redirect PC; payload
  // is left as-is since the bubble is never consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= '0;
      ir_q      <= NOP_IR;
      data_q    <= '0;
      ctrl_q    <= '0;
      flushed_q <= 1'b0;
    end else if (bus.flush) begin
      pc_q      <= bus.in_pc;
      ir_q      <= NOP_IR;
      ctrl_q    <= ctrl_q & ~KILL_MASK;
      flushed_q <= 1'b1;
    end else begin
      if (load_main) begin
        pc_q   <= main_pc_d;
        ir_q   <= main_ir_d;
        data_q <= main_data_d;
        ctrl_q <= main_ctrl_d;
      end
      if (in_xfer) begin
        flushed_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = in_ready_i;
  assign bus.out_valid   = out_valid_i;
  assign bus.out_pc      = pc_q;
  assign bus.out_ir      = ir_q;
  assign bus.out_data    = data_q;
  assign bus.out_ctrl    = ctrl_q;
  assign bus.out_flushed = flushed_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg. The reference model is a FIFO of accepted beats
// whose capacity is the stage depth (1 without skid, 2 with skid); the head
// of the FIFO is what the stage must present.
module tb_pipe_stage_reg;

  localparam int unsigned DW  = 64;
  localparam int unsigned CW  = 24;
  localparam logic [CW-1:0] KILL = '1;
  localparam logic [31:0]   NOP  = 32'h0000_0013;

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   ir;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } beat_t;

  logic clk;
  logic rst;

  pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus ();

  pipe_stage_reg #(
    .DATA_W   (DW),
    .CTRL_W   (CW),
    .KILL_MASK(KILL),
    .NOP_IR   (NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- monitor
  beat_t         q[$];
  logic          active   = 1'b0;
  logic          m_flushed;
  logic [CW-1:0] cur_ctrl;
  logic          pend_rst   = 1'b0;
  logic          pend_flush = 1'b0;
  logic [31:0]   exp_fpc;
  logic [CW-1:0] exp_fctrl;

  initial begin : monitor
    logic  r, f, ixfer, oxfer, exp_rdy;
    beat_t b;
    forever begin
      @(negedge clk);
      if (active) begin
        if (pend_rst) begin
          chk("rst_valid",   bus.out_valid,   1'b0);
          chk("rst_pc",      bus.out_pc,      32'h0);
          chk("rst_ir",      bus.out_ir,      NOP);
          chk("rst_data",    bus.out_data,    64'h0);
          chk("rst_ctrl",    bus.out_ctrl,    '0);
          chk("rst_flushed", bus.out_flushed, 1'b0);
          chk("rst_ready",   bus.in_ready,    1'b1);
        end
        if (pend_flush) begin
          chk("flush_valid",   bus.out_valid,   1'b0);
          chk("flush_flag",    bus.out_flushed, 1'b1);
          chk("flush_ir",      bus.out_ir,      NOP);
          chk("flush_ctrl",    bus.out_ctrl,    exp_fctrl);
          chk("flush_pc",      bus.out_pc,      exp_fpc);
        end
`ifdef PIPE_STAGE_SKID_EN
        exp_rdy = (q.size() < 2);
`else
        exp_rdy = (q.size() == 0) || bus.out_ready;
`endif
        chk("valid_model",   bus.out_valid,   q.size() != 0);
        chk("ready_model",   bus.in_ready,    exp_rdy);
        chk("flushed_model", bus.out_flushed, m_flushed);
        if (q.size() > 0) begin
          chk("head_pc",   bus.out_pc,   q[0].pc);
          chk("head_ir",   bus.out_ir,   q[0].ir);
          chk("head_data", bus.out_data, q[0].data);
          chk("head_ctrl", bus.out_ctrl, q[0].ctrl);
        end
      end

      r     = rst;
      f     = bus.flush;
      ixfer = bus.in_valid && bus.in_ready && !f && !r;
      oxfer = bus.out_valid && bus.out_ready && !r;
      pend_rst   = 1'b0;
      pend_flush = 1'b0;

      if (r) begin
        q.delete();
        m_flushed = 1'b0;
        cur_ctrl  = '0;
        pend_rst  = 1'b1;
        active    = 1'b1;
      end else if (active) begin
        if (oxfer) begin
          if (q.size() == 0) chk("spurious_beat", 64'd1, 64'd0);
          else b = q.pop_front();
        end
        if (ixfer) begin
          b.pc   = bus.in_pc;
          b.ir   = bus.in_ir;
          b.data = bus.in_data;
          b.ctrl = bus.in_ctrl;
          q.push_back(b);
        end
        if (f) begin
          exp_fpc    = bus.in_pc;
          exp_fctrl  = cur_ctrl & ~KILL;
          cur_ctrl   = exp_fctrl;
          q.delete();
          m_flushed  = 1'b1;
          pend_flush = 1'b1;
        end else begin
          if (ixfer) m_flushed = 1'b0;
          if (q.size() > 0) cur_ctrl = q[0].ctrl;
        end
      end
    end
  end

  // --------------------------------------------------------------- stimulus
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [31:0] pc);
    bus.in_pc   = pc;
    bus.in_ir   = $urandom;
    bus.in_data = {$urandom, $urandom};
    bus.in_ctrl = CW'($urandom);
  endtask

  // Holds in_valid until the beat is taken (bounded).
  task automatic wait_accept();
    bus.in_valid = 1'b1;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (bus.in_ready) break;
      if (i >= 100) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout: actual=in_ready stuck low required=accept pc=%h", bus.in_pc);
        break;
      end
    end
    cycle();
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] pc);
    set_beat(pc);
    wait_accept();
  endtask

  initial begin : stim
    rst           = 1'b1;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    set_beat(32'h0);
    repeat (2) cycle();
    rst = 1'b0;
    cycle();

    // Back-to-back beats, downstream always ready.
    bus.out_ready = 1'b1;
    send(32'h100);
    send(32'h104);
    send(32'h108);
    repeat (3) cycle();

    // Downstream stall while a second beat is pending.
    bus.out_ready = 1'b0;
    send(32'h200);
    set_beat(32'h204);
`ifdef PIPE_STAGE_SKID_EN
    wait_accept();
    repeat (2) cycle();
    bus.out_ready = 1'b1;
`else
    bus.in_valid = 1'b1;
    repeat (3) cycle();
    bus.out_ready = 1'b1;
    wait_accept();
`endif
    repeat (3) cycle();

    // Flush with a beat offered in the same cycle.
    set_beat(32'h300);
    bus.in_ctrl  = '1;
    bus.in_valid = 1'b1;
    bus.flush    = 1'b1;
    cycle();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) cycle();

    // Flush with the stage full (both entries in the skid build).
    bus.out_ready = 1'b0;
    send(32'h3a0);
`ifdef PIPE_STAGE_SKID_EN
    send(32'h3a4);
`endif
    bus.flush = 1'b1;
    cycle();
    bus.flush = 1'b0;
    bus.out_ready = 1'b1;
    send(32'h400);
    repeat (3) cycle();

    // Reset with the stage full and downstream stalled.
    bus.out_ready = 1'b0;
    send(32'h500);
`ifdef PIPE_STAGE_SKID_EN
    send(32'h504);
`endif
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (2) cycle();

    // Randomised traffic with occasional flush and reset.
    for (int n = 0; n < 3000; n++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.flush     = ($urandom_range(0, 23) == 0);
      rst           = ($urandom_range(0, 299) == 0);
      set_beat($urandom & 32'hffff_fffc);
      cycle();
    end

    rst           = 1'b0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) cycle();
    @(negedge clk);
    chk("drained", q.size(), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
